// File: rtl/sine_pwm_dac_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sine_pwm_dac_pkg
//  Description : Shared sizing constants for the sine-table / PWM-DAC path.
//                Offset-binary samples are SAMPLE_W bits wide with midscale
//                at MIDSCALE; one PWM period spans PERIOD counter ticks.
//  Revision    : 1.0  initial release
// ============================================================================
package sine_pwm_dac_pkg;

    // Default sample resolution exponent (sample is N+1 bits)
    localparam int unsigned N_DEFAULT = 7;

    localparam int unsigned SAMPLE_W  = N_DEFAULT + 1;
    localparam int unsigned MIDSCALE  = 2 ** N_DEFAULT;
    localparam int unsigned PERIOD    = 2 ** (N_DEFAULT + 1);

    // Period length in ticks for an arbitrary resolution exponent
    function automatic int unsigned period_ticks(input int unsigned n);
        return 2 ** (n + 1);
    endfunction

endpackage : sine_pwm_dac_pkg
`default_nettype wire

// File: rtl/sine_pwm_dac_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pwm_tick_gen
//  Description : Rate prescaler. Emits a single-clock tick once every
//                2^N_DIVIDE clocks while run is high; the count is held at
//                zero while run is low so the first tick after run rises
//                lands a full division later. N_DIVIDE = 0 ties tick high.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                run   - count enable; low clears the prescaler
//                tick  - advance strobe for the downstream counter
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_tick_gen #(
    parameter int unsigned N_DIVIDE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    generate
        if (N_DIVIDE == 0) begin : g_no_div
            // No division: every clock is a tick, the clock/reset are idle
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, run};
            assign tick     = 1'b1;
        end else begin : g_div
            logic [N_DIVIDE-1:0] r_presc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_presc <= '0;
                end else if (!run) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + N_DIVIDE'(1);
                end
            end

            // Terminal count of the prescaler; it wraps to zero next clock
            assign tick = &r_presc;
        end
    endgenerate

endmodule : pwm_tick_gen
`default_nettype wire

// File: rtl/sine_pwm_dac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sine_pwm_dac
//  Description : Converts offset-binary samples into a single-bit PWM stream
//                for an external RC filter. Samples enter a one-entry holding
//                register over valid/ready and are promoted to the active duty
//                value only at period boundaries, so no period is glitched.
//                An empty holding register at a boundary raises underrun.
//  Ports       : clk          - system clock (rising edge)
//                rst_n        - asynchronous active-low reset
//                enable       - run PWM; low parks counter at 0, output low
//                sample_in    - offset-binary sample, N+1 bits
//                sample_valid - sample_in valid this cycle
//                sample_ready - holding register empty (registered)
//                pwm_out      - registered PWM output
//                period_start - pulse with the first pwm_out bit of a period
//                underrun     - pulse at a boundary with nothing to consume
//  Revision    : 1.0  initial release
// ============================================================================
module sine_pwm_dac
    import sine_pwm_dac_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned N_DIVIDE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N:0]   sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic         pwm_out,
    output logic         period_start,
    output logic         underrun
);

    localparam logic [N:0] c_cnt_one  = (N+1)'(1);
    localparam logic [N:0] c_cnt_max  = {(N+1){1'b1}};
    localparam logic [N:0] c_midscale = c_cnt_one << N;

    logic       w_tick;
    logic       w_boundary;
    logic       w_xfer;
    logic       w_consume;
    logic       w_hold_full_nxt;

    logic [N:0] r_cnt;
    logic [N:0] r_active;
    logic [N:0] r_hold;
    logic       r_hold_full;
    logic       r_ready;
    logic       r_pwm;
    logic       r_zero_new;
    logic       r_period_start;
    logic       r_underrun;

    // ------------------------------------------------------------------
    // Tick prescaler
    // ------------------------------------------------------------------
    pwm_tick_gen #(
        .N_DIVIDE (N_DIVIDE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (enable),
        .tick  (w_tick)
    );

    assign w_boundary = enable && w_tick && (r_cnt == c_cnt_max);
    assign w_xfer     = sample_valid && r_ready;
    assign w_consume  = w_boundary && r_hold_full;

    // Ready is low whenever hold is full, so a transfer never coincides with
    // a consume; a transfer in an empty boundary cycle only fills hold.
    always_comb begin
        w_hold_full_nxt = r_hold_full;
        if (w_consume) begin
            w_hold_full_nxt = 1'b0;
        end
        if (w_xfer) begin
            w_hold_full_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and active duty value
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b0;
            r_active    <= c_midscale;
        end else begin
            if (w_xfer) begin
                r_hold <= sample_in;
            end
            if (w_consume) begin
                r_active <= r_hold;
            end
            r_hold_full <= w_hold_full_nxt;
            // Ready reflects the hold state that takes effect this edge so a
            // held-high valid cannot overwrite an unconsumed sample.
            r_ready     <= !w_hold_full_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm          <= 1'b0;
            r_zero_new     <= 1'b1;
            r_period_start <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_pwm          <= enable && (r_cnt < r_active);
            // cnt=0 is fresh on the clock after a wrap or after any disabled
            // clock; with a prescaler cnt=0 persists for several clocks and
            // only the first of them marks the period start.
            r_zero_new     <= !enable || w_boundary;
            r_period_start <= enable && r_zero_new;
            r_underrun     <= w_boundary && !r_hold_full;
        end
    end

    assign sample_ready = r_ready;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign underrun     = r_underrun;

endmodule : sine_pwm_dac
`default_nettype wire

// File: tb/tb_sine_pwm_dac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sine_pwm_dac
//  Description : Self-checking bench for sine_pwm_dac. A per-clock reference
//                model (position in period, active duty, pending-sample queue)
//                checks the undivided instance; period-level tables and
//                hand sequences cover duty extremes, handshake and reset
//                corners; a second instance checks the divided tick rate.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sine_pwm_dac;
    import sine_pwm_dac_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Undivided instance
    logic       enable = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sample_ready;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;

    // Divide-by-4 instance
    logic       en2 = 1'b0;
    logic       v2 = 1'b0;
    logic [7:0] s2 = 8'd0;
    logic       rdy2;
    logic       pwm2;
    logic       ps2;
    logic       ur2;

    always #5 clk = ~clk;

    sine_pwm_dac #(.N(7), .N_DIVIDE(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun)
    );

    sine_pwm_dac #(.N(7), .N_DIVIDE(2)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (en2),
        .sample_in    (s2),
        .sample_valid (v2),
        .sample_ready (rdy2),
        .pwm_out      (pwm2),
        .period_start (ps2),
        .underrun     (ur2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_pos;
    int         m_active;
    bit         m_ready;
    bit         m_fresh;
    logic [7:0] hold_q[$];

    // Per-window statistics from the DUT
    int n_high;
    int n_ps;
    int n_ur;
    int n_nrdy;

    typedef struct {
        bit send;
        int pos;
        int value;
        int exp_high;
        int exp_ur;
        int exp_nrdy;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_active = MIDSCALE;
        hold_q.delete();
        m_ready  = 1'b0;
        m_fresh  = 1'b1;
    endtask

    // One clock of the undivided instance, checked against the model
    task automatic cycle();
        bit e_pwm;
        bit e_ps;
        bit e_ur;
        bit bnd;
        bit acc;
        @(posedge clk);
        e_pwm = enable && (m_pos < m_active);
        e_ps  = enable && (m_pos == 0) && m_fresh;
        bnd   = enable && (m_pos == PERIOD - 1);
        e_ur  = bnd && (hold_q.size() == 0);
        acc   = sample_valid && m_ready;
        if (bnd && hold_q.size() != 0) m_active = int'(hold_q.pop_front());
        if (acc) hold_q.push_back(sample_in);
        m_ready = (hold_q.size() == 0);
        m_fresh = !enable || bnd;
        m_pos   = enable ? (m_pos + 1) % PERIOD : 0;
        #1;
        chk("pwm_out",      int'(pwm_out),      int'(e_pwm));
        chk("period_start", int'(period_start), int'(e_ps));
        chk("underrun",     int'(underrun),     int'(e_ur));
        chk("sample_ready", int'(sample_ready), int'(m_ready));
        if (pwm_out)       n_high++;
        if (period_start)  n_ps++;
        if (underrun)      n_ur++;
        if (!sample_ready) n_nrdy++;
    endtask

    // One full period; valid is high for positions p0..p1, first value v0
    task automatic run_period(input bit send, input int p0, input int p1,
                              input int v0, input int v1);
        n_high = 0; n_ps = 0; n_ur = 0; n_nrdy = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (send && i >= p0 && i <= p1) begin
                sample_valid = 1'b1;
                sample_in    = (i == p0) ? 8'(v0) : 8'(v1);
            end else begin
                sample_valid = 1'b0;
            end
            cycle();
        end
        sample_valid = 1'b0;
    endtask

    task automatic period_checks(input string tag, input int eh, input int eu);
        chk({tag, " high"},      n_high, eh);
        chk({tag, " underruns"}, n_ur,   eu);
        chk({tag, " starts"},    n_ps,   1);
    endtask

    initial begin
        // Period-level vectors: a sample sent during period k is active in k+1
        vt[0] = '{1'b0,   0,   0, 128, 1,   0};
        vt[1] = '{1'b1, 100,  64, 128, 0, 155};
        vt[2] = '{1'b1, 100,   0,  64, 0, 155};
        vt[3] = '{1'b1, 100, 255,   0, 0, 155};
        vt[4] = '{1'b0,   0,   0, 255, 1,   0};
        vt[5] = '{1'b1, 100,   1, 255, 0, 155};
        vt[6] = '{1'b0,   0,   0,   1, 1,   0};
        vt[7] = '{1'b1, 255, 200,   1, 1,   1};
        vt[8] = '{1'b0,   0,   0,   1, 0, 255};
        vt[9] = '{1'b0,   0,   0, 200, 1,   0};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset pwm_out",      int'(pwm_out),      0);
        chk("reset period_start", int'(period_start), 0);
        chk("reset underrun",     int'(underrun),     0);
        chk("reset dut2 pwm_out", int'(pwm2),         0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();                       // ready rises one clock after release
        chk("ready after release", int'(sample_ready), 1);
        chk("dut2 ready after release", int'(rdy2), 1);

        // ---------------- table-driven periods ----------------
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run_period(vt[k].send, vt[k].pos, vt[k].pos, vt[k].value, vt[k].value);
            period_checks($sformatf("vec%0d", k), vt[k].exp_high, vt[k].exp_ur);
            chk($sformatf("vec%0d ready-low clocks", k), n_nrdy, vt[k].exp_nrdy);
        end

        // ---------------- valid held while not ready ----------------
        run_period(1'b1, 50, 200, 10, 99);
        period_checks("held-valid A", 200, 0);
        run_period(1'b0, 0, 0, 0, 0);
        period_checks("held-valid B", 10, 1);
        run_period(1'b1, 100, 100, 220, 220);
        period_checks("held-valid C", 10, 0);

        // ---------------- reset mid-period with hold full ----------------
        for (int i = 0; i <= 100; i++) begin
            sample_valid = (i == 50);
            sample_in    = 8'd30;
            cycle();
        end
        sample_valid = 1'b0;
        chk("pre-reset pwm_out", int'(pwm_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset pwm_out",  int'(pwm_out),      0);
        chk("async reset start",    int'(period_start), 0);
        chk("async reset underrun", int'(underrun),     0);
        @(posedge clk);
        #1;
        chk("held reset pwm_out", int'(pwm_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_period(1'b0, 0, 0, 0, 0);
        period_checks("post-reset P1", 128, 1);
        run_period(1'b0, 0, 0, 0, 0);
        period_checks("post-reset P2", 128, 1);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) enable = ~enable;
            sample_valid = ($urandom_range(0, 149) == 0);
            sample_in    = 8'($urandom_range(0, 255));
            cycle();
        end
        enable       = 1'b0;
        sample_valid = 1'b0;

        // ---------------- divide-by-4 instance ----------------
        begin
            bit found;
            int hi;
            int ur;
            int mid_ps;
            @(negedge clk);
            v2 = 1'b1;
            s2 = 8'd32;
            @(negedge clk);
            v2 = 1'b0;
            chk("dut2 ready after disabled transfer", int'(rdy2), 0);
            en2 = 1'b1;
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                @(negedge clk);
                if (ps2) found = 1'b1;
            end
            chk("dut2 first period_start", int'(found), 1);
            for (int p = 0; p < 2; p++) begin
                hi = int'(pwm2);
                ur = int'(ur2);
                mid_ps = 0;
                for (int k = 1; k < 1024; k++) begin
                    @(negedge clk);
                    hi += int'(pwm2);
                    ur += int'(ur2);
                    mid_ps += int'(ps2);
                end
                @(negedge clk);
                chk($sformatf("dut2 P%0d high clocks", p), hi, (p == 0) ? 512 : 128);
                chk($sformatf("dut2 P%0d underruns", p), ur, (p == 0) ? 0 : 1);
                chk($sformatf("dut2 P%0d early starts", p), mid_ps, 0);
                chk($sformatf("dut2 P%0d start at 1024", p), int'(ps2), 1);
            end
            en2 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sine_pwm_dac
`default_nettype wire
